// File: rtl/ft_rf_reader.sv
// Fault-tolerant register-file reader: reads two replicas, checks parity, repairs a bad copy.
// Latency: response 3 cycles after req_i is presented (4 when a scrub write is inserted).
// Backpressure: single outstanding read; ready_o high only in IDLE, req_i ignored otherwise.
//
// Ports:
//   clk_i / rstn_i          clock, asynchronous active-low reset
//   req_i, addr_i, ready_o  request handshake (accept = req_i & ready_o)
//   valid_o, addr_o, data_o, signal_o, err_cnt_o   response + status
//   rd_addr_{a,b}_o, rd_data_{a,b}_i, rd_par_{a,b}_i  replica read ports (1-cycle sync read)
//   we_{a,b}_o, wr_addr_o, wr_data_o, wr_par_o         scrub write port
// Build option: define FT_SCRUB_EN to enable scrub write-back of a repaired replica.
// Without it the same status codes and data selection apply, but no write is issued.
module ft_rf_reader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            signal_o,
  output logic [7:0]            err_cnt_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_a_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_b_o,
  input  logic [DATA_WIDTH-1:0] rd_data_a_i,
  input  logic [DATA_WIDTH-1:0] rd_data_b_i,
  input  logic                  rd_par_a_i,
  input  logic                  rd_par_b_i,
  output logic                  we_a_o,
  output logic                  we_b_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  wr_par_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CMP   = 3'd2,
    SCRUB = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [1:0] SIG_CLEAN  = 2'b00;
  localparam logic [1:0] SIG_FIX_B  = 2'b01;
  localparam logic [1:0] SIG_FIX_A  = 2'b10;
  localparam logic [1:0] SIG_UNCORR = 2'b11;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [1:0]             signal_q, signal_d;
  logic [7:0]             err_cnt_q, err_cnt_d;

  logic                   accept;
  logic                   ok_a, ok_b;
  logic [DATA_WIDTH-1:0]  cmp_data;
  logic [1:0]             cmp_sig;
  logic                   cmp_scrub;

  assign accept = req_i && (state_q == IDLE);

  // Even parity: a copy is good when the XOR of its data bits equals its stored bit.
  assign ok_a = ((^rd_data_a_i) == rd_par_a_i);
  assign ok_b = ((^rd_data_b_i) == rd_par_b_i);

  // Replica arbitration, only meaningful while in CMP.
  always_comb begin
    cmp_data = rd_data_a_i;
    cmp_sig  = SIG_UNCORR;
    case ({ok_a, ok_b})
      2'b11: cmp_sig = (rd_data_a_i == rd_data_b_i) ? SIG_CLEAN : SIG_UNCORR;
      2'b10: cmp_sig = SIG_FIX_B;
      2'b01: begin
        cmp_data = rd_data_b_i;
        cmp_sig  = SIG_FIX_A;
      end
      default: cmp_sig = SIG_UNCORR;
    endcase
  end

`ifdef FT_SCRUB_EN
  // Exactly one copy bad -> rewrite it from the good one.
  assign cmp_scrub = ok_a ^ ok_b;
`else
  assign cmp_scrub = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = CMP;
      CMP:     state_d = cmp_scrub ? SCRUB : RESP;
      SCRUB:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_comb begin
    addr_d    = accept ? addr_i : addr_q;
    // Response fields are frozen at CMP exit and held until the next CMP.
    data_d    = (state_q == CMP) ? cmp_data : data_q;
    signal_d  = (state_q == CMP) ? cmp_sig  : signal_q;
    err_cnt_d = err_cnt_q;
    // Count on RESP entry; signal_d already carries the code for this response.
    if ((state_d == RESP) && (state_q != RESP) && (signal_d != SIG_CLEAN) &&
        (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q    <= '0;
      data_q    <= '0;
      signal_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      addr_q    <= addr_d;
      data_q    <= data_d;
      signal_q  <= signal_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef FT_SCRUB_EN
  // Scrub payload: target is whichever copy failed parity, source the good copy.
  logic                  scrub_to_a_q, scrub_to_a_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_par_q, wr_par_d;

  always_comb begin
    scrub_to_a_d = scrub_to_a_q;
    wr_data_d    = wr_data_q;
    wr_par_d     = wr_par_q;
    if (state_q == CMP) begin
      scrub_to_a_d = ~ok_a;
      wr_data_d    = ok_a ? rd_data_a_i : rd_data_b_i;
      wr_par_d     = ok_a ? rd_par_a_i  : rd_par_b_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      scrub_to_a_q <= 1'b0;
      wr_data_q    <= '0;
      wr_par_q     <= 1'b0;
    end else begin
      scrub_to_a_q <= scrub_to_a_d;
      wr_data_q    <= wr_data_d;
      wr_par_q     <= wr_par_d;
    end
  end
`endif

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ready_o     = (state_q == IDLE);
    valid_o     = (state_q == RESP);
    rd_addr_a_o = ((state_q == READ) || (state_q == CMP)) ? addr_q : '0;
    rd_addr_b_o = rd_addr_a_o;
`ifdef FT_SCRUB_EN
    // Write strobes decode straight from state_q so reset kills them immediately.
    we_a_o      = (state_q == SCRUB) &&  scrub_to_a_q;
    we_b_o      = (state_q == SCRUB) && !scrub_to_a_q;
    wr_addr_o   = (state_q == SCRUB) ? addr_q    : '0;
    wr_data_o   = (state_q == SCRUB) ? wr_data_q : '0;
    wr_par_o    = (state_q == SCRUB) && wr_par_q;
`else
    we_a_o      = 1'b0;
    we_b_o      = 1'b0;
    wr_addr_o   = '0;
    wr_data_o   = '0;
    wr_par_o    = 1'b0;
`endif
  end

  assign addr_o    = addr_q;
  assign data_o    = data_q;
  assign signal_o  = signal_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_ft_rf_reader.sv
module tb_ft_rf_reader;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef FT_SCRUB_EN
  localparam bit SCRUB = 1'b1;
`else
  localparam bit SCRUB = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          req_i;
  logic [AW-1:0] addr_i;
  logic          ready_o, valid_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] data_o;
  logic [1:0]    signal_o;
  logic [7:0]    err_cnt_o;
  logic [AW-1:0] rd_addr_a_o, rd_addr_b_o;
  logic [DW-1:0] rd_data_a_i, rd_data_b_i;
  logic          rd_par_a_i, rd_par_b_i;
  logic          we_a_o, we_b_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          wr_par_o;

  always #5 clk_i = ~clk_i;

  ft_rf_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .addr_i(addr_i),
    .ready_o(ready_o), .valid_o(valid_o), .addr_o(addr_o), .data_o(data_o),
    .signal_o(signal_o), .err_cnt_o(err_cnt_o),
    .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o),
    .rd_data_a_i(rd_data_a_i), .rd_data_b_i(rd_data_b_i),
    .rd_par_a_i(rd_par_a_i), .rd_par_b_i(rd_par_b_i),
    .we_a_o(we_a_o), .we_b_o(we_b_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .wr_par_o(wr_par_o)
  );

  // Replica storage with 1-cycle synchronous read.
  logic [DW-1:0] mem_a [32];
  logic [DW-1:0] mem_b [32];
  logic          par_a [32];
  logic          par_b [32];

  always @(posedge clk_i) begin
    rd_data_a_i <= mem_a[rd_addr_a_o];
    rd_data_b_i <= mem_b[rd_addr_b_o];
    rd_par_a_i  <= par_a[rd_addr_a_o];
    rd_par_b_i  <= par_b[rd_addr_b_o];
  end

  int checks   = 0;
  int failures = 0;
  int exp_err  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int bump(input int cnt);
    return (cnt < 255) ? cnt + 1 : 255;
  endfunction

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] a;
    logic          pa;
    logic [DW-1:0] b;
    logic          pb;
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_sig;
    logic          fix_a;   // A is the bad copy, scrub writes A
    logic          fix_b;
  } vec_t;

  vec_t vecs[7];

  // Issues one read, returns edges from presentation to valid_o plus captured observations.
  task automatic do_read(input logic [AW-1:0] a, output int lat, output int nwa, output int nwb,
                         output logic [AW-1:0] waddr, output logic [DW-1:0] wdata,
                         output logic wpar, output logic [DW-1:0] rdata,
                         output logic [1:0] rsig, output logic [AW-1:0] raddr);
    bit got;
    got = 0; lat = 0; nwa = 0; nwb = 0;
    waddr = '0; wdata = '0; wpar = 1'b0; rdata = '0; rsig = '0; raddr = '0;
    @(posedge clk_i); #1;
    req_i = 1'b1; addr_i = a;
    while (!got && lat < 12) begin
      @(posedge clk_i); #1;
      req_i = 1'b0;
      lat++;
      if (we_a_o || we_b_o) begin
        if (we_a_o) nwa++;
        if (we_b_o) nwb++;
        waddr = wr_addr_o; wdata = wr_data_o; wpar = wr_par_o;
      end
      if (valid_o) begin
        got = 1; rdata = data_o; rsig = signal_o; raddr = addr_o;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL read_timeout actual=no_valid required=valid_within_12");
    end
  endtask

  initial begin
    int lat, nwa, nwb, nvld, nwe;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata, rdata;
    logic          wpar;
    logic [1:0]    rsig;

    for (int i = 0; i < 32; i++) begin
      mem_a[i] = '0; mem_b[i] = '0; par_a[i] = 1'b0; par_b[i] = 1'b0;
    end
    //            addr  A             pA    B             pB    data          sig    fixA  fixB
    vecs[0] = '{5'd10, 32'd100,       1'b1, 32'd100,       1'b1, 32'd100,       2'b00, 1'b0, 1'b0};
    vecs[1] = '{5'd10, 32'd100,       1'b1, 32'd101,       1'b1, 32'd100,       2'b01, 1'b0, 1'b1};
    vecs[2] = '{5'd3,  32'd1,         1'b0, 32'd3,         1'b0, 32'd3,         2'b10, 1'b1, 1'b0};
    vecs[3] = '{5'd10, 32'd100,       1'b1, 32'd36,        1'b0, 32'd100,       2'b11, 1'b0, 1'b0};
    vecs[4] = '{5'd7,  32'd101,       1'b1, 32'd100,       1'b0, 32'd101,       2'b11, 1'b0, 1'b0};
    vecs[5] = '{5'd31, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 2'b00, 1'b0, 1'b0};
    vecs[6] = '{5'd0,  32'd0,         1'b0, 32'h8000_0000, 1'b0, 32'd0,         2'b01, 1'b0, 1'b1};

    rstn_i = 1'b0; req_i = 1'b0; addr_i = '0;
    #12 rstn_i = 1'b1;
    #1;
    check("rst_ready",   ready_o,   1);
    check("rst_valid",   valid_o,   0);
    check("rst_data",    data_o,    0);
    check("rst_signal",  signal_o,  0);
    check("rst_err_cnt", err_cnt_o, 0);
    check("rst_we",      {we_a_o, we_b_o}, 0);
    check("rst_rd_addr", rd_addr_a_o, 0);
    check("rst_wr_data", wr_data_o, 0);

    // ---------------- table-driven reads ----------------
    for (int v = 0; v < 7; v++) begin
      bit scrubbed;
      mem_a[vecs[v].addr] = vecs[v].a; par_a[vecs[v].addr] = vecs[v].pa;
      mem_b[vecs[v].addr] = vecs[v].b; par_b[vecs[v].addr] = vecs[v].pb;
      scrubbed = SCRUB && (vecs[v].fix_a || vecs[v].fix_b);
      do_read(vecs[v].addr, lat, nwa, nwb, waddr, wdata, wpar, rdata, rsig, raddr);
      if (vecs[v].exp_sig != 2'b00) exp_err = bump(exp_err);
      check($sformatf("v%0d_latency", v), lat, scrubbed ? 4 : 3);
      check($sformatf("v%0d_data", v), rdata, vecs[v].exp_data);
      check($sformatf("v%0d_signal", v), rsig, vecs[v].exp_sig);
      check($sformatf("v%0d_addr", v), raddr, vecs[v].addr);
      check($sformatf("v%0d_we_a_cnt", v), nwa, (SCRUB && vecs[v].fix_a) ? 1 : 0);
      check($sformatf("v%0d_we_b_cnt", v), nwb, (SCRUB && vecs[v].fix_b) ? 1 : 0);
      if (scrubbed) begin
        check($sformatf("v%0d_wr_addr", v), waddr, vecs[v].addr);
        check($sformatf("v%0d_wr_data", v), wdata, vecs[v].exp_data);
        check($sformatf("v%0d_wr_par", v), wpar, vecs[v].fix_a ? vecs[v].pb : vecs[v].pa);
      end
      check($sformatf("v%0d_err_cnt", v), err_cnt_o, exp_err);
      @(posedge clk_i); #1;
      check($sformatf("v%0d_valid_pulse", v), valid_o, 0);
      check($sformatf("v%0d_ready_back", v), ready_o, 1);
      check($sformatf("v%0d_data_held", v), data_o, vecs[v].exp_data);
      check($sformatf("v%0d_sig_held", v), signal_o, vecs[v].exp_sig);
    end

    // ---------------- req_i during READ is ignored ----------------
    mem_a[12] = 32'h55; par_a[12] = 1'b0; mem_b[12] = 32'h55; par_b[12] = 1'b0;
    mem_a[20] = 32'h77; par_a[20] = 1'b1; mem_b[20] = 32'h77; par_b[20] = 1'b1;
    @(posedge clk_i); #1; req_i = 1'b1; addr_i = 5'd12;
    @(posedge clk_i); #1; addr_i = 5'd20;        // accepted; now in READ
    check("busy_ready_low", ready_o, 0);
    @(posedge clk_i); #1; req_i = 1'b0;
    nvld = 0; raddr = '0; rdata = '0;
    for (int c = 0; c < 10; c++) begin
      if (valid_o) begin nvld++; raddr = addr_o; rdata = data_o; end
      @(posedge clk_i); #1;
    end
    check("ignore_valid_cnt", nvld, 1);
    check("ignore_addr", raddr, 12);
    check("ignore_data", rdata, 32'h55);

    // ---------------- reset in the middle of SCRUB ----------------
    mem_a[5] = 32'd100; par_a[5] = 1'b1; mem_b[5] = 32'd101; par_b[5] = 1'b1;
    @(posedge clk_i); #1; req_i = 1'b1; addr_i = 5'd5;
    @(posedge clk_i); #1; req_i = 1'b0;          // READ
    @(posedge clk_i); #1;                         // CMP
    @(posedge clk_i); #1;                         // SCRUB when enabled
    check("mid_scrub_we_b", we_b_o, SCRUB ? 1 : 0);
    #2 rstn_i = 1'b0;
    #1;
    check("arst_we", {we_a_o, we_b_o}, 0);
    check("arst_valid", valid_o, 0);
    check("arst_err_cnt", err_cnt_o, 0);
    check("arst_signal", signal_o, 0);
    exp_err = 0;
    @(negedge clk_i); rstn_i = 1'b1;
    nvld = 0; nwe = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk_i); #1;
      if (valid_o) nvld++;
      if (we_a_o || we_b_o) nwe++;
    end
    check("post_rst_valid_cnt", nvld, 0);
    check("post_rst_we_cnt", nwe, 0);
    check("post_rst_ready", ready_o, 1);

    // ---------------- error counter saturation ----------------
    mem_a[10] = 32'd100; par_a[10] = 1'b1; mem_b[10] = 32'd36; par_b[10] = 1'b0;
    for (int n = 0; n < 256; n++) begin
      do_read(5'd10, lat, nwa, nwb, waddr, wdata, wpar, rdata, rsig, raddr);
      exp_err = bump(exp_err);
      if (n == 253) check("sat_cnt_254", err_cnt_o, exp_err);
    end
    check("sat_cnt_255", err_cnt_o, 255);
    check("sat_last_signal", rsig, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ft_rf_reader.md
FT_RF_READER -- requirements
Module: ft_rf_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 5, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, 32, register data width.
REQ-003 clk_i  in  1  sole clock, all state on rising edge.
REQ-004 rstn_i  in  1  reset, asynchronous, active-low.
REQ-005 req_i  in  1  read request; accepted when req_i & ready_o at rising edge.
REQ-006 addr_i  in  ADDR_WIDTH  read address, sampled at accept.
REQ-007 ready_o  out  1  high only in IDLE.
REQ-008 valid_o  out  1  one-cycle response strobe.
REQ-009 addr_o  out  ADDR_WIDTH  address of current response.
REQ-010 data_o  out  DATA_WIDTH  read data.
REQ-011 signal_o  out  2  status: 00 clean, 01 B repaired from A, 10 A repaired from B, 11 uncorrectable.
REQ-012 err_cnt_o  out  8  saturating count of responses with signal_o != 00.
REQ-013 rd_addr_a_o, rd_addr_b_o  out  ADDR_WIDTH  replica read addresses.
REQ-014 rd_data_a_i, rd_data_b_i  in  DATA_WIDTH  replica data, 1-cycle synchronous read latency.
REQ-015 rd_par_a_i, rd_par_b_i  in  1  stored even-parity bit per replica.
REQ-016 we_a_o, we_b_o  out  1  scrub write enables to replica A and B.
REQ-017 wr_addr_o  out  ADDR_WIDTH; wr_data_o  out  DATA_WIDTH; wr_par_o  out  1  scrub write payload.

Function
REQ-018 FSM states IDLE, READ, CMP, SCRUB, RESP; IDLE->READ on accept; READ->CMP; CMP->SCRUB or RESP; SCRUB->RESP; RESP->IDLE, all unconditional except as stated.
REQ-019 Address SHALL be registered at accept and drive rd_addr_a_o/rd_addr_b_o in READ and CMP.
REQ-020 Replica copy SHALL be parity-good when XOR of rd_data_x_i equals rd_par_x_i, evaluated in CMP.
REQ-021 Both good and equal: data_o=A, signal_o=00, CMP->RESP.
REQ-022 Both good and unequal: data_o=A, signal_o=11, no scrub, CMP->RESP.
REQ-023 A good, B bad: data_o=A, signal_o=01, CMP->SCRUB writing A data/parity to B.
REQ-024 A bad, B good: data_o=B, signal_o=10, CMP->SCRUB writing B data/parity to A.
REQ-025 Both bad: data_o=A, signal_o=11, no scrub, CMP->RESP.
REQ-026 we_a_o/we_b_o SHALL be high only during SCRUB, at most one of them, for exactly one cycle.
REQ-027 valid_o SHALL be high only in RESP; data_o/addr_o/signal_o held stable from CMP exit until next accept.
REQ-028 Latency accept edge to valid_o: 3 cycles clean/uncorrectable, 4 cycles with scrub.
REQ-029 req_i outside IDLE SHALL be ignored; no queuing.
REQ-030 err_cnt_o SHALL increment on RESP entry when signal_o != 00, saturating at 255.

Reset
REQ-031 rstn_i low SHALL immediately force IDLE, ready_o=1 after release, all other outputs 0, err_cnt_o=0.
REQ-032 Reset in any state, including SCRUB, SHALL abort the operation; no scrub write or response after release.

Configuration
REQ-033 Macro FT_SCRUB_EN defined: scrub behaviour per REQ-023/024/026.
REQ-034 FT_SCRUB_EN undefined: SCRUB never entered, we_a_o/we_b_o constant 0, signal_o codes and data_o selection unchanged, latency always 3.

Verification
REQ-035 Clean read: addr 10, both replicas 100 parity 1 -> valid_o 3 cycles later, data_o=100, signal_o=00, no we.
REQ-036 B parity error: addr 10, A=100/p1, B=101/p1 -> we_b_o one cycle, wr_addr_o=10, wr_data_o=100, wr_par_o=1; data_o=100, signal_o=01, latency 4, err_cnt_o=1.
REQ-037 A parity error: A=0x0000_0001/p0, B=0x0000_0003/p0 -> we_a_o, wr_data_o=3, data_o=3, signal_o=10.
REQ-038 Uncorrectable: A=100/p1, B=36/p0 (both good, unequal) -> signal_o=11, data_o=100, no we, latency 3.
REQ-039 Reset mid-SCRUB -> we_x_o drop asynchronously, no valid_o, err_cnt_o=0; req_i during READ ignored; 256 errors -> err_cnt_o stays 255.
REQ-040 Build without FT_SCRUB_EN, repeat REQ-036 -> signal_o=01, data_o=100, no we, latency 3.
